// File: rtl/maxpool_2x2_if.sv
// Streaming bus for the 2x2 max-pool: map samples in, pooled samples out.
// Signals: map_size, map_in, map_in_valid (in); pool_out, pool_out_valid, frame_done (out).
interface maxpool_2x2_if #(
   parameter int DATA_W = 16
);
   logic        [8:0]        map_size;
   logic signed [DATA_W-1:0] map_in;
   logic                     map_in_valid;
   logic signed [DATA_W-1:0] pool_out;
   logic                     pool_out_valid;
   logic                     frame_done;

   modport master (
      output map_size,
      output map_in,
      output map_in_valid,
      input  pool_out,
      input  pool_out_valid,
      input  frame_done
   );

   modport slave (
      input  map_size,
      input  map_in,
      input  map_in_valid,
      output pool_out,
      output pool_out_valid,
      output frame_done
   );
endinterface

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 signed max-pool over a raster NxN map (N latched per frame).
// Ports: sys_clk, sys_rst_n (sync, active-low), mp (maxpool_2x2_if.slave).
// Build option: define MAXPOOL_RELU_EN to clamp negative results to 0.
module maxpool_2x2 #(
   parameter int DATA_W  = 16,
   parameter int MAX_MAP = 256
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   maxpool_2x2_if.slave  mp
);
   localparam int LB_D  = MAX_MAP / 2;
   localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

   logic        [8:0]        col_q, col_d;
   logic        [8:0]        row_q, row_d;
   logic        [8:0]        size_q, size_d;
   logic signed [DATA_W-1:0] pair_q, pair_d;
   logic signed [DATA_W-1:0] pool_q, pool_d;
   logic                     pv_q, pv_d;
   logic                     fd_q, fd_d;

   logic signed [DATA_W-1:0] lb_mem [LB_D];
   logic                     lb_we;
   logic        [LB_AW-1:0]  lb_idx;
   logic signed [DATA_W-1:0] lb_rd;
   logic signed [DATA_W-1:0] hmax;
   logic signed [DATA_W-1:0] pmax;

   logic        [8:0]        n_eff;
   logic        [8:0]        n_one;
   logic        [8:0]        n_even;
   logic                     first;
   logic                     col_last;
   logic                     row_last;
   logic                     in_win;

   always_comb begin
      first  = (col_q == 9'd0) && (row_q == 9'd0);
      // The first sample of a frame uses the live size it is latching.
      n_eff  = first ? mp.map_size : size_q;
      n_one  = (n_eff == 9'd0) ? 9'd1 : n_eff;
      // Odd trailing row/column fall outside every window.
      n_even = {n_one[8:1], 1'b0};
      col_last = (col_q == n_one - 9'd1);
      row_last = (row_q == n_one - 9'd1);
      in_win   = (col_q < n_even) && (row_q < n_even);

      lb_idx = col_q[LB_AW:1];
      lb_rd  = lb_mem[lb_idx];
      hmax   = (pair_q > mp.map_in) ? pair_q : mp.map_in;
      pmax   = (lb_rd > hmax) ? lb_rd : hmax;

      col_d  = col_q;
      row_d  = row_q;
      size_d = size_q;
      pair_d = pair_q;
      pool_d = pool_q;
      pv_d   = 1'b0;
      fd_d   = 1'b0;
      lb_we  = 1'b0;

      if (mp.map_in_valid) begin
         if (first) size_d = mp.map_size;
         if (col_last) begin
            col_d = 9'd0;
            row_d = row_last ? 9'd0 : row_q + 9'd1;
         end else begin
            col_d = col_q + 9'd1;
         end
         fd_d = col_last && row_last;
         if (in_win) begin
            if (!col_q[0]) begin
               pair_d = mp.map_in;
            end else if (!row_q[0]) begin
               lb_we = 1'b1;
            end else begin
               pv_d = 1'b1;
`ifdef MAXPOOL_RELU_EN
               pool_d = pmax[DATA_W-1] ? '0 : pmax;
`else
               pool_d = pmax;
`endif
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         col_q  <= '0;
         row_q  <= '0;
         size_q <= '0;
         pair_q <= '0;
         pool_q <= '0;
         pv_q   <= 1'b0;
         fd_q   <= 1'b0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         size_q <= size_d;
         pair_q <= pair_d;
         pool_q <= pool_d;
         pv_q   <= pv_d;
         fd_q   <= fd_d;
      end
   end

   // Every entry is written on an even row before its odd-row read.
   always_ff @(posedge sys_clk) begin
      if (lb_we) lb_mem[lb_idx] <= hmax;
   end

   assign mp.pool_out       = pool_q;
   assign mp.pool_out_valid = pv_q;
   assign mp.frame_done     = fd_q;
endmodule

// File: tb/tb_maxpool_2x2.sv
// Scoreboard bench for maxpool_2x2: directed frames, queued expectations.
// A negedge monitor pops and checks value and arrival cycle.
module tb_maxpool_2x2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   typedef struct {
      int                 cyc;
      logic signed [15:0] val;
   } exp_t;

   exp_t               oq[$];
   int                 fq[$];
   logic signed [15:0] last_out = '0;

   maxpool_2x2_if #(.DATA_W(16)) bus ();

   maxpool_2x2 #(
      .DATA_W(16),
      .MAX_MAP(256)
   ) dut (
      .sys_clk(clk),
      .sys_rst_n(rst_n),
      .mp(bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: cycle %0d reached, required finish", cyc);
      $fatal(1, "timeout");
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.pool_out_valid) begin
            n_tests++;
            if (oq.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_out: got %0d at cyc %0d, required none",
                        bus.pool_out, cyc);
            end else begin
               exp_t e;
               e = oq.pop_front();
               if (bus.pool_out !== e.val || cyc != e.cyc) begin
                  n_fail++;
                  $display("FAIL pool_out: got %0d at cyc %0d, required %0d at cyc %0d",
                           bus.pool_out, cyc, e.val, e.cyc);
               end
            end
            last_out = bus.pool_out;
         end else begin
            n_tests++;
            if (bus.pool_out !== last_out) begin
               n_fail++;
               $display("FAIL hold: got %0d, required %0d", bus.pool_out, last_out);
            end
         end
         if (oq.size() > 0 && oq[0].cyc < cyc) begin
            exp_t m;
            m = oq.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_out: got nothing, required %0d at cyc %0d",
                     m.val, m.cyc);
         end
         if (bus.frame_done) begin
            n_tests++;
            if (fq.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_fd: got pulse at cyc %0d, required none", cyc);
            end else begin
               int c;
               c = fq.pop_front();
               if (c != cyc) begin
                  n_fail++;
                  $display("FAIL frame_done: got cyc %0d, required cyc %0d", cyc, c);
               end
            end
         end
         if (fq.size() > 0 && fq[0] < cyc) begin
            int m;
            m = fq.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_fd: got nothing, required cyc %0d", m);
         end
      end
   end

   task automatic smp(input int v, input bit ov, input int ovv, input bit fd);
      exp_t e;
      @(negedge clk);
      bus.map_in = 16'(v);
      bus.map_in_valid = 1'b1;
      if (ov) begin
         e.cyc = cyc + 1;
         e.val = 16'(ovv);
         oq.push_back(e);
      end
      if (fd) fq.push_back(cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.map_in_valid = 1'b0;
         bus.map_in = 16'h5a5a;
      end
   endtask

   task automatic chk(input string nm, input int got, input int req);
      n_tests++;
      if (got != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", nm, got, req);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.map_in_valid = 1'b0;
      @(negedge clk);
      chk("rst_pool_out", int'(bus.pool_out), 0);
      chk("rst_valid", int'(bus.pool_out_valid), 0);
      chk("rst_frame_done", int'(bus.frame_done), 0);
      last_out = '0;
      rst_n = 1'b1;
   endtask

   function automatic bit is_out4(input int i);
      return i == 5 || i == 7 || i == 13 || i == 15;
   endfunction

   initial begin
      bus.map_size = 9'd4;
      bus.map_in = '0;
      bus.map_in_valid = 1'b0;
      repeat (2) @(negedge clk);
      do_reset();

      // N=4 continuous: outputs 5,7,13,15
      for (int i = 0; i < 16; i++) smp(i, is_out4(i), i, i == 15);
      idle(3);

      // N=5: outputs 6,8,16,18; last row/col dropped
      bus.map_size = 9'd5;
      for (int i = 0; i < 25; i++)
         smp(i, i == 6 || i == 8 || i == 16 || i == 18, i, i == 24);
      idle(3);

      // N=4 with idle gaps between samples
      bus.map_size = 9'd4;
      for (int i = 0; i < 16; i++) begin
         smp(i, is_out4(i), i, i == 15);
         idle(1);
      end
      idle(2);

      // N=2 all negative
      bus.map_size = 9'd2;
      smp(-3, 0, 0, 0);
      smp(-7, 0, 0, 0);
      smp(-1, 0, 0, 0);
`ifdef MAXPOOL_RELU_EN
      smp(-9, 1, 0, 1);
`else
      smp(-9, 1, -1, 1);
`endif
      // N=2 all equal to the most negative value
      smp(-32768, 0, 0, 0);
      smp(-32768, 0, 0, 0);
      smp(-32768, 0, 0, 0);
`ifdef MAXPOOL_RELU_EN
      smp(-32768, 1, 0, 1);
`else
      smp(-32768, 1, -32768, 1);
`endif
      // N=2 maximum in top-left position
      smp(9, 0, 0, 0);
      smp(3, 0, 0, 0);
      smp(2, 0, 0, 0);
      smp(1, 1, 9, 1);
      idle(3);

      // mid-frame reset abandons the partial frame
      bus.map_size = 9'd4;
      for (int i = 0; i < 6; i++) smp(i + 100, i == 5, 105, 0);
      idle(2);
      do_reset();
      for (int i = 0; i < 16; i++) smp(i, is_out4(i), i, i == 15);
      idle(3);

      // size change mid-frame applies to the next frame only
      bus.map_size = 9'd4;
      for (int i = 0; i < 16; i++) begin
         if (i == 4) bus.map_size = 9'd6;
         smp(i, is_out4(i), i, i == 15);
      end
      for (int i = 0; i < 36; i++)
         smp(i, ((i / 6) % 2 == 1) && ((i % 6) % 2 == 1), i, i == 35);
      idle(3);

      // N=1 and N=0: every sample ends a frame, no output
      bus.map_size = 9'd1;
      for (int i = 0; i < 3; i++) smp(i + 50, 0, 0, 1);
      idle(1);
      bus.map_size = 9'd0;
      for (int i = 0; i < 2; i++) smp(i + 60, 0, 0, 1);
      idle(4);

      chk("drain_out_q", oq.size(), 0);
      chk("drain_fd_q", fq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
